// File: rtl/cmd_queue.sv
// Command queue between the AHB slave decoder and the execution FSM.
// Host push beats are assembled into CMD_WIDTH entries. The FSM may only
// fetch once a WRITE-type command has committed the sequence. Includes
// a STATUS/CTRL register, a debug read-back window and error detection.
module cmd_queue #(
   parameter int DATA_WIDTH = 32,
   parameter int BEATS      = 2,
   parameter int CMD_DEPTH  = 128,
   parameter int ADDR_WIDTH = 32,
   parameter int TYPE_W     = 2
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  cmd_en,
   input  logic                                  slv_o_valid,
   input  logic [ADDR_WIDTH-1:0]                 slv_o_addr,
   input  logic [DATA_WIDTH-1:0]                 slv_o_wr_data,
   input  logic                                  slv_o_rd0_wr1,
   output logic                                  slv_i_ready,
   output logic [DATA_WIDTH-1:0]                 slv_i_rd_data,
   output logic                                  slv_i_rd_valid,
   input  logic                                  cmd_rd_en,
   input  logic [$clog2(CMD_DEPTH)-1:0]          cmd_addr,
   output logic [DATA_WIDTH*BEATS-1:0]           cmd_out,
   output logic                                  cmd_rd_valid,
   output logic                                  cmd_rd_err,
   output logic [$clog2(CMD_DEPTH):0]            cmd_count,
   output logic                                  seq_done,
   output logic                                  seq_err
);

   localparam int CMD_WIDTH = DATA_WIDTH * BEATS;
   localparam int IDX_W     = $clog2(CMD_DEPTH);
   localparam int CNT_W     = IDX_W + 1;
   localparam int BEAT_W    = $clog2(BEATS);
   localparam int WORD_W    = ADDR_WIDTH - 2;
   localparam int STG_W     = DATA_WIDTH * (BEATS - 1);

   typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_DONE, S_ERROR} state_t;

   // read response source selector
   localparam logic [1:0] RSP_ZERO   = 2'd0;
   localparam logic [1:0] RSP_STATUS = 2'd1;
   localparam logic [1:0] RSP_DEBUG  = 2'd2;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [BEAT_W-1:0]       beat_q, beat_d;
   logic [STG_W-1:0]        staging_q, staging_d;
   logic                    rd_pend_q, rd_pend_d;
   logic [1:0]              rd_sel_q, rd_sel_d;
   logic [DATA_WIDTH-1:0]   status_q, status_d;
   logic [BEAT_W-1:0]       dbg_beat_q, dbg_beat_d;
   logic                    fetch_ok_q, fetch_ok_d;
   logic                    fetch_err_q, fetch_err_d;

   logic [CMD_WIDTH-1:0]    mem [CMD_DEPTH];
   logic [CMD_WIDTH-1:0]    fetch_data_q;
   logic [CMD_WIDTH-1:0]    dbg_data_q;
   logic [DATA_WIDTH-1:0]   dbg_lane [BEATS];

   logic [WORD_W-1:0]       word;
   logic [WORD_W-1:0]       dbg_off;
   logic [WORD_W-1:0]       dbg_entry;
   logic [IDX_W-1:0]        dbg_idx;
   logic                    dbg_hit;
   logic                    accept, rd_acc, wr_acc, push, ctrl_clr;
   logic                    full, last_beat, can_fill, store;
   logic [CMD_WIDTH-1:0]    mem_wr_data;
   logic [DATA_WIDTH-1:0]   status_w;
   logic                    addr_lsb_unused;

   // bus decode, debug window address split and command completion
   always_comb begin
      word        = slv_o_addr[ADDR_WIDTH-1:2];
      accept      = cmd_en && slv_o_valid && slv_i_ready;
      wr_acc      = accept && slv_o_rd0_wr1;
      rd_acc      = accept && !slv_o_rd0_wr1;
      push        = wr_acc && (word == '0);
      ctrl_clr    = wr_acc && (word == WORD_W'(1)) && slv_o_wr_data[0];
      dbg_off     = word - WORD_W'(2);
      dbg_entry   = dbg_off >> BEAT_W;
      dbg_idx     = dbg_entry[IDX_W-1:0];
      dbg_hit     = (word >= WORD_W'(2)) && (dbg_entry < WORD_W'(count_q));
      full        = (count_q == CNT_W'(CMD_DEPTH));
      last_beat   = (beat_q == BEAT_W'(BEATS - 1));
      can_fill    = (state_q == S_EMPTY) || (state_q == S_FILLING);
      store       = push && can_fill && last_beat && !full;
      mem_wr_data = {slv_o_wr_data, staging_q};
      status_w        = '0;
      status_w[31:16] = 16'(count_q);
      status_w[15:8]  = 8'(beat_q);
      status_w[2]     = full;
      status_w[1]     = (state_q == S_ERROR);
      status_w[0]     = (state_q == S_DONE);
      addr_lsb_unused = ^slv_o_addr[1:0];
   end

   // state register plus all control/datapath flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_EMPTY;
         count_q     <= '0;
         beat_q      <= '0;
         staging_q   <= '0;
         rd_pend_q   <= 1'b0;
         rd_sel_q    <= RSP_ZERO;
         status_q    <= '0;
         dbg_beat_q  <= '0;
         fetch_ok_q  <= 1'b0;
         fetch_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         beat_q      <= beat_d;
         staging_q   <= staging_d;
         rd_pend_q   <= rd_pend_d;
         rd_sel_q    <= rd_sel_d;
         status_q    <= status_d;
         dbg_beat_q  <= dbg_beat_d;
         fetch_ok_q  <= fetch_ok_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   // next-state: commit on WRITE type, error on overflow or push after commit
   always_comb begin
      state_d = state_q;
      if (ctrl_clr) begin
         state_d = S_EMPTY;
      end else if (push) begin
         case (state_q)
            S_EMPTY, S_FILLING: begin
               if (last_beat) begin
                  if (full)
                     state_d = S_ERROR;
                  else if (staging_q[TYPE_W-1:0] == TYPE_W'(0))
                     state_d = S_DONE;
                  else
                     state_d = S_FILLING;
               end
            end
            S_DONE:  state_d = S_ERROR;
            default: state_d = S_ERROR;
         endcase
      end
   end

   // beat assembly, entry count, read response and fetch decisions
   always_comb begin
      count_d     = count_q;
      beat_d      = beat_q;
      staging_d   = staging_q;
      if (ctrl_clr) begin
         count_d = '0;
         beat_d  = '0;
      end else if (push && can_fill) begin
         if (last_beat) begin
            beat_d = '0;
            if (!full)
               count_d = count_q + CNT_W'(1);
         end else begin
            staging_d[beat_q*DATA_WIDTH +: DATA_WIDTH] = slv_o_wr_data;
            beat_d = beat_q + BEAT_W'(1);
         end
      end

      rd_pend_d  = rd_acc;
      rd_sel_d   = RSP_ZERO;
      status_d   = status_w;
      dbg_beat_d = dbg_off[BEAT_W-1:0];
      if (rd_acc && (word == WORD_W'(1)))
         rd_sel_d = RSP_STATUS;
      else if (rd_acc && dbg_hit)
         rd_sel_d = RSP_DEBUG;

      fetch_ok_d  = cmd_rd_en && (state_q == S_DONE) && ({1'b0, cmd_addr} < count_q);
      fetch_err_d = cmd_rd_en && !fetch_ok_d;
   end

   // command memory: one write port, registered FSM and debug read ports
   always_ff @(posedge clk) begin
      if (store)
         mem[count_q[IDX_W-1:0]] <= mem_wr_data;
      if (cmd_rd_en)
         fetch_data_q <= mem[cmd_addr];
      if (rd_acc)
         dbg_data_q <= mem[dbg_idx];
   end

   // split the debug read word into bus-width lanes
   generate
      for (genvar gi = 0; gi < BEATS; gi++) begin : g_dbg_lane
         assign dbg_lane[gi] = dbg_data_q[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // outputs: strobes straight from flops, data gated to zero when idle
   always_comb begin
      seq_done       = (state_q == S_DONE);
      seq_err        = (state_q == S_ERROR);
      slv_i_ready    = !rd_pend_q;
      slv_i_rd_valid = rd_pend_q;
      slv_i_rd_data  = '0;
      if (rd_pend_q && (rd_sel_q == RSP_STATUS))
         slv_i_rd_data = status_q;
      else if (rd_pend_q && (rd_sel_q == RSP_DEBUG))
         slv_i_rd_data = dbg_lane[dbg_beat_q];
      cmd_out        = fetch_ok_q ? fetch_data_q : '0;
      cmd_rd_valid   = fetch_ok_q;
      cmd_rd_err     = fetch_err_q;
      cmd_count      = count_q;
   end

endmodule
